// File: rtl/stream_pkg.sv
// Shared stream helpers: lane-index sizing, lowest-set-bit search and
// one-hot detection. Used by both the downsizer and the upsizer.
package stream_pkg;

  // Widest lane mask the helpers accept; narrower masks are zero-extended.
  localparam int unsigned MAX_RATIO = 64;
  localparam int unsigned MAX_IDX_W = 6;

  typedef logic [MAX_RATIO-1:0] mask_t;

  // Width of a lane index for a given lane count (never below one bit).
  function automatic int unsigned lane_idx_width(input int unsigned ratio);
    return (ratio > 32'd1) ? 32'($clog2(ratio)) : 32'd1;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [MAX_IDX_W-1:0] find_first_set(input mask_t mask);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_RATIO - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = MAX_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic is_onehot(input mask_t mask);
    return (mask != '0) && ((mask & (mask - mask_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/stream_lane_sel.sv
// Combinational priority encoder over the pending-lane mask: picks the
// lowest pending lane, produces the mask with that lane retired, and flags
// the final pending lane.
module stream_lane_sel
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_RATIO = 4,
  parameter int unsigned IDX_W        = 2
) (
  input  logic [T_DATA_RATIO-1:0] mask_i,
  output logic [IDX_W-1:0]        idx_o,
  output logic [T_DATA_RATIO-1:0] onehot_clear_o,
  output logic                    single_o
);

  // Lowest pending lane, mask with it cleared, and single-lane flag.
  always_comb begin
    idx_o          = IDX_W'(find_first_set(mask_t'(mask_i)));
    onehot_clear_o = mask_i & (mask_i - T_DATA_RATIO'(1));
    single_o       = is_onehot(mask_t'(mask_i));
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: holds one wide beat and emits its kept
// lanes lowest-first, one per handshake. A new wide beat may load in the
// same cycle the final lane leaves, so back-to-back beats have no bubble.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_DATA_RATIO = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [T_DATA_RATIO-1:0]                     s_keep_i,
  input  logic                                        s_last_i,
  input  logic                                        s_valid_i,
  output logic                                        s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                     m_data_o,
  output logic                                        m_last_o,
  output logic                                        m_valid_o,
  input  logic                                        m_ready_i,
  output logic                                        drop_last_o
);

  localparam int unsigned IDX_W = lane_idx_width(T_DATA_RATIO);

  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] data_q, data_d;
  logic [T_DATA_RATIO-1:0]                   mask_q, mask_d;
  logic                                      last_q, last_d;
  logic                                      drop_q, drop_d;

  logic [IDX_W-1:0]        lane_idx;
  logic [T_DATA_RATIO-1:0] mask_next;
  logic                    lane_single;
  logic                    accept;
  logic                    out_hs;

  stream_lane_sel #(
    .T_DATA_RATIO (T_DATA_RATIO),
    .IDX_W        (IDX_W)
  ) u_lane_sel (
    .mask_i         (mask_q),
    .idx_o          (lane_idx),
    .onehot_clear_o (mask_next),
    .single_o       (lane_single)
  );

  // Handshakes and outputs; m_* depend only on the holding registers.
  always_comb begin
    m_valid_o   = (mask_q != '0);
    m_data_o    = data_q[lane_idx];
    m_last_o    = last_q && lane_single;
    drop_last_o = drop_q;
    s_ready_o   = (mask_q == '0) || (m_ready_i && lane_single);
    accept      = s_valid_i && s_ready_o;
    out_hs      = m_valid_o && m_ready_i;
  end

  // Next state: retire the sent lane, or load a fresh wide beat on accept.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    last_d = last_q;
    drop_d = 1'b0;
    if (accept) begin
      data_d = s_data_i;
      mask_d = s_keep_i;
      last_d = s_last_i;
      drop_d = s_last_i && (s_keep_i == '0);
    end else if (out_hs) begin
      mask_d = mask_next;
    end else begin
      mask_d = mask_q;
    end
  end

  // Holding registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      last_q <= last_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: doc/stream_downsize.md
# stream_downsize

Width down-converter for the valid/ready stream interface: accepts one wide beat of `T_DATA_RATIO` lanes with a per-lane keep mask and emits the kept lanes as narrow beats, lowest lane first. It is the counterpart of the stream upsizer and sits on the egress side, where a wide internal datapath feeds a narrow consumer. Packet boundaries are preserved: `m_last_o` marks the final kept lane of a wide beat that carried `s_last_i`.

## Interface
- `T_DATA_WIDTH`, default 8: width of one lane / narrow beat, ≥1.
- `T_DATA_RATIO`, default 4: lanes per wide beat, ≥2.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `s_data_i`  in  `[T_DATA_WIDTH-1:0]` × `[T_DATA_RATIO]`  wide beat; element 0 is the first lane.
- `s_keep_i`  in  `T_DATA_RATIO`  lane valid mask; bit i qualifies `s_data_i[i]`.
- `s_last_i`  in  1  wide beat ends a packet.
- `s_valid_i`  in  1  upstream valid.
- `s_ready_o`  out  1  upstream ready.
- `m_data_o`  out  `T_DATA_WIDTH`  narrow beat.
- `m_last_o`  out  1  final narrow beat of the packet.
- `m_valid_o`  out  1  downstream valid.
- `m_ready_i`  in  1  downstream ready.
- `drop_last_o`  out  1  one-cycle pulse: a zero-keep beat carrying `s_last_i` was consumed.

## Operation
- Holding registers: `data_q` (all lanes), `mask_q` (lanes still to send), `last_q`.
- States:
  - IDLE: `mask_q == 0`.
  - DRAIN: `mask_q != 0`.
- Accept occurs when `s_valid_i && s_ready_o`. On accept, load `data_q = s_data_i`, `mask_q = s_keep_i`, and `last_q = s_last_i`.
- In DRAIN:
  - `m_valid_o = 1`.
  - `m_data_o = data_q[idx]`, where `idx` is the lowest set bit of `mask_q`.
  - `m_last_o = last_q && (mask_q has exactly one bit set)`.
- On each output handshake, clear bit `idx` in `mask_q`. Unkept lanes are skipped with no bubble.
- `s_ready_o = (mask_q == 0) || (m_ready_i && mask_q has one bit set)`. This lets a new beat load in the same cycle the final lane is handshaken, so there is no bubble between wide beats. `s_ready_o` depends combinationally on `m_ready_i`; `m_*` outputs are driven only from registers.
- Zero-keep beat:
  - Accepted in one cycle; emits nothing and the block stays in IDLE.
  - If it carries `s_last_i`, pulse `drop_last_o` the following cycle. Upstream must not rely on this beat to delimit a packet.
- Stability: while `m_valid_o && !m_ready_i`, `m_data_o` and `m_last_o` hold.
- Reset: all outputs are 0 except `s_ready_o`, which is 1 because `mask_q == 0`. Reset mid-drain discards the remaining lanes; no partial packet is completed.

## Timing
- Latency from wide-beat accept at cycle N to the first narrow beat valid: cycle N+1.
- A beat with k kept lanes occupies exactly k cycles of output under continuous `m_ready_i`. Back-to-back beats sustain 1 narrow beat per cycle.
- `drop_last_o` asserts at N+1 for a zero-keep last beat accepted at N.
- An output handshake and an input accept in the same cycle are legal only on the final lane. The new beat's first lane appears on the next cycle.

## Structure
- Shared package `stream_pkg`:
  - lane-index width constant `$clog2(T_DATA_RATIO)`, used via a parameterised function;
  - `find_first_set` function returning the lowest set bit index;
  - `is_onehot` helper.
  The upsizer reuses these helpers.
- One sub-module, `stream_lane_sel`: a purely combinational priority encoder. Input is `mask_q`; outputs are `idx`, `onehot_clear` (the mask with the lowest set bit cleared), and `single` (exactly one bit set).
- Top: registers, handshake logic, output mux.

## Test plan
Common setup: `T_DATA_WIDTH=8`, `T_DATA_RATIO=4`, `m_ready_i=1` unless stated.
1. One beat, lanes 0..3 = `0x11,0x22,0x33,0x44`, keep `4'b1111`, last=1 → `m_data_o` is `0x11,0x22,0x33,0x44` on 4 consecutive cycles starting N+1; `m_last_o` only with `0x44`; `s_ready_o` low for 3 cycles.
2. Keep `4'b1010`, lanes `0xA0,0xA1,0xA2,0xA3`, last=1 → only `0xA1` then `0xA3` (last) over 2 cycles; `s_ready_o` high again on the `0xA3` cycle.
3. Two back-to-back full beats, last=0 then last=1 → 8 narrow beats in 8 consecutive cycles with no gap; `m_last_o` only on beat 8.
4. `m_ready_i` pattern 1,0,0,1,1,0,1 during a full beat → `m_data_o`/`m_last_o` stable whenever valid && !ready; no lane lost or duplicated; `s_ready_o` stays 0 until the final lane handshakes.
5. Zero-keep beat with last=1 → no `m_valid_o`; `drop_last_o` high for exactly one cycle at N+1; `s_ready_o` stays 1.
6. `rst_n=0` for one cycle after the 2nd lane of a full beat → next cycle `m_valid_o=0`, `s_ready_o=1`; the remaining lanes never appear; the next beat drains normally.
